interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 Parameter VECTOR_BASE, default 8'h40: vector address of the highest-priority source (bit 0).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 iClock  in  1  sole clock; all state updates on its rising edge.
REQ-004 iReset  in  1  synchronous, active-high reset.
REQ-005 iIrq  in  5  single-cycle request pulses: [0] VBlank, [1] LCD STAT, [2] timer overflow, [3] serial, [4] joypad.
REQ-006 iEof  in  1  end-of-instruction strobe from the CPU.
REQ-007 iEi / iDi / iReti  in  1 each  EI, DI and RETI executed (one-cycle pulses).
REQ-008 iIfWe / iIeWe  in  1 each  CPU write strobes for IF (0xFF0F) and IE (0xFFFF).
REQ-009 iMcuWriteData  in  8  CPU write data.
REQ-010 iIrqAck  in  1  CPU accepts the offered interrupt.
REQ-011 oIf  out  8  {3'b111, IF[4:0]}.
REQ-012 oIe  out  8  IE register.
REQ-013 oIrqReq  out  1  interrupt offered to the CPU.
REQ-014 oIrqVector  out  8  dispatch address; stable while oIrqReq=1.
REQ-015 oWake  out  1  |(IF & IE[4:0]) regardless of IME; used for HALT exit.

Function
REQ-016 IF bit n sets on the cycle after iIrq[n]=1; a set bit stays set until it is written to 0 or cleared by dispatch.
REQ-017 On an IF write, IF = data[4:0] | iIrq; a hardware request wins over a write of 0 in the same cycle.
REQ-018 IE write stores all 8 bits; only IE[4:0] take part in arbitration.
REQ-019 Priority: the lowest set bit of (IF & IE[4:0]) wins; vector = VECTOR_BASE + 8*n (0x40, 0x48, 0x50, 0x58, 0x60).
REQ-020 FSM states: IDLE, REQ, DISPATCH; encodings live in the shared definitions.
REQ-021 IDLE -> REQ when IME=1 and the pending set is non-zero; the winner index and vector are latched on that edge, and oIrqReq=1 from the next cycle.
REQ-022 REQ -> DISPATCH on iIrqAck; oIrqReq falls on the next cycle.
REQ-023 REQ -> IDLE (request withdrawn, oIrqReq=0 on the next cycle) if IME clears or the latched IF bit is cleared before ack.
REQ-024 On entry to DISPATCH: the latched IF bit clears and IME=0.
REQ-025 If a new iIrq on the same bit arrives in that cycle, the bit remains set.
REQ-026 DISPATCH -> IDLE unconditionally after one cycle; there is no re-arbitration during DISPATCH.
REQ-027 The latched vector does not change while in REQ, even if a higher-priority bit arrives.
REQ-028 iReti sets IME=1 on the next cycle with no delay.
REQ-029 iDi clears IME on the next cycle and cancels any pending EI.
REQ-030 If iEi and iDi coincide, DI wins.
REQ-031 iEi behaviour is defined in Configuration.

Reset
REQ-032 While iReset=1 at the clock edge: IF=0 (oIf=0xE0), IE=0x00, IME=0, EI-pending=0, state=IDLE, oIrqReq=0, oIrqVector=0x00, oWake=0.
REQ-033 Reset asserted in REQ or DISPATCH aborts the dispatch without clearing any further IF bit; iIrq is ignored during reset.

Configuration
REQ-034 Macro INTCTRL_EI_DELAY_EN, defined: iEi sets EI-pending, and IME becomes 1 on the cycle after the first iEof strictly after the iEi cycle.
REQ-035 INTCTRL_EI_DELAY_EN undefined: iEi sets IME on the next cycle, and no EI-pending flop exists.

Structure
REQ-036 The shared definitions header holds: FSM state encodings, source bit indices, and vector constants.
REQ-037 One sub-module, irq_priority_enc, is combinational: a 5-bit input gives a found flag and a 3-bit index.
REQ-038 All flops live in interrupt_ctrl.

Verification
REQ-039 Scenario 1: IE=0x04, EI, iEof, then iIrq[2] pulse -> oIrqReq=1 two cycles after the pulse, vector 0x50; ack -> IF=0xE0, IME=0, oIrqReq=0 the next cycle.
REQ-040 Scenario 2: IE=0x1F, IME=1, iIrq=5'b10110 together -> vector 0x48; after dispatch and RETI -> vector 0x50, then 0x60.
REQ-041 Scenario 3: in REQ, IF write 0x00 before ack -> oIrqReq drops the next cycle, state IDLE, and no IME change.
REQ-042 Scenario 4: IF write 0x00 in the same cycle as iIrq[0] -> oIf=0xE1.
REQ-043 Scenario 5 (INTCTRL_EI_DELAY_EN): iEi then an iEof 3 cycles later -> IME=0 until the cycle after that iEof; iEi+iDi together -> IME stays 0.
REQ-044 Scenario 6: IME=0, IE=0x01, iIrq[0] -> oWake=1, oIrqReq stays 0; iReset mid-REQ -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/interrupt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl_pkg
// Shared definitions for the interrupt controller: arbitration FSM state
// encodings, interrupt source bit indices, dispatch vector constants, the
// latched-winner payload and the vector computation helper.
// No ports (package).
// -----------------------------------------------------------------------------
package interrupt_ctrl_pkg;

  localparam int unsigned NUM_IRQ = 5;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DATA_W  = 8;

  // Source bit positions in IF / IE; bit 0 has the highest priority
  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  // Dispatch addresses for the default vector base
  localparam logic [DATA_W-1:0] VEC_VBLANK = 8'h40;
  localparam logic [DATA_W-1:0] VEC_STAT   = 8'h48;
  localparam logic [DATA_W-1:0] VEC_TIMER  = 8'h50;
  localparam logic [DATA_W-1:0] VEC_SERIAL = 8'h58;
  localparam logic [DATA_W-1:0] VEC_JOYPAD = 8'h60;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_DISPATCH = 2'd2
  } ctrlState_t;

  // Winner captured when a request is offered; held until the next offer
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] vector;
  } irqLatch_t;

  // Vector of source idx: base + 8*idx
  function automatic logic [DATA_W-1:0] irqVector(input logic [DATA_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + DATA_W'({idx, 3'b000});
  endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl_if
// CPU-side bus of the interrupt controller.
//   master (CPU side) drives: iIrq, iEof, iEi, iDi, iReti, iIfWe, iIeWe,
//                             iMcuWriteData, iIrqAck
//   slave  (controller) drives: oIf, oIe, oIrqReq, oIrqVector, oWake
// -----------------------------------------------------------------------------
interface interrupt_ctrl_if;
  import interrupt_ctrl_pkg::*;

  logic [NUM_IRQ-1:0] iIrq;
  logic               iEof;
  logic               iEi;
  logic               iDi;
  logic               iReti;
  logic               iIfWe;
  logic               iIeWe;
  logic [DATA_W-1:0]  iMcuWriteData;
  logic               iIrqAck;
  logic [DATA_W-1:0]  oIf;
  logic [DATA_W-1:0]  oIe;
  logic               oIrqReq;
  logic [DATA_W-1:0]  oIrqVector;
  logic               oWake;

  modport master (
    output iIrq, iEof, iEi, iDi, iReti, iIfWe, iIeWe, iMcuWriteData, iIrqAck,
    input  oIf, oIe, oIrqReq, oIrqVector, oWake
  );

  modport slave (
    input  iIrq, iEof, iEi, iDi, iReti, iIfWe, iIeWe, iMcuWriteData, iIrqAck,
    output oIf, oIe, oIrqReq, oIrqVector, oWake
  );

endinterface

// File: rtl/interrupt_ctrl_priority_enc.sv
// -----------------------------------------------------------------------------
// irq_priority_enc
// Combinational lowest-set-bit encoder used for interrupt arbitration.
//   iPending  in  NUM_IRQ  enabled-and-flagged sources
//   oFound_c  out 1        any bit set
//   oIndex_c  out IDX_W    index of the lowest set bit (0 when none)
// -----------------------------------------------------------------------------
module irq_priority_enc
  import interrupt_ctrl_pkg::*;
(
  input  logic [NUM_IRQ-1:0] iPending,
  output logic               oFound_c,
  output logic [IDX_W-1:0]   oIndex_c
);

  // Scan high to low so the lowest set bit is the last one written
  always_comb begin
    oFound_c = 1'b0;
    oIndex_c = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (iPending[i]) begin
        oFound_c = 1'b1;
        oIndex_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl
// IF/IE/IME interrupt controller with fixed-priority arbitration and a
// request/acknowledge handshake towards the CPU.
//   iClock       in   sole clock, rising edge
//   iReset       in   synchronous active-high reset
//   bus          slave modport of interrupt_ctrl_if:
//                  iIrq/iEof/iEi/iDi/iReti/iIfWe/iIeWe/iMcuWriteData/iIrqAck in,
//                  oIf/oIe/oIrqReq/oIrqVector/oWake out
// Parameter VECTOR_BASE: dispatch address of source 0.
// Build option INTCTRL_EI_DELAY_EN: when defined, EI takes effect only after
// the next end-of-instruction strobe; otherwise EI enables IME immediately.
// -----------------------------------------------------------------------------
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter logic [7:0] VECTOR_BASE = 8'h40
) (
  input  logic             iClock,
  input  logic             iReset,
  interrupt_ctrl_if.slave  bus
);

  logic [NUM_IRQ-1:0] ifReg;
  logic [DATA_W-1:0]  ieReg;
  logic               ime;
  ctrlState_t         state;
  irqLatch_t          winLatch;
  logic               irqReq;

  logic [NUM_IRQ-1:0] pending;
  logic               found;
  logic [IDX_W-1:0]   winIdx;
  logic [NUM_IRQ-1:0] ifBase;
  logic               imeBase;
  logic               eiFire;

  assign pending = ifReg & ieReg[NUM_IRQ-1:0];

  irq_priority_enc uPriorityEnc (
    .iPending (pending),
    .oFound_c (found),
    .oIndex_c (winIdx)
  );

`ifdef INTCTRL_EI_DELAY_EN
  logic eiPending;

  // EI arms a pending enable that fires on a later end-of-instruction
  assign eiFire = eiPending & bus.iEof;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      eiPending <= 1'b0;
    end else if (bus.iDi) begin
      eiPending <= 1'b0;
    end else if (bus.iEi) begin
      eiPending <= 1'b1;
    end else if (bus.iEof) begin
      eiPending <= 1'b0;
    end
  end
`else
  logic unusedEof;

  assign eiFire    = bus.iEi;
  assign unusedEof = bus.iEof;
`endif

  // IF after hardware requests and CPU writes; a request beats a written 0
  always_comb begin
    ifBase = ifReg | bus.iIrq;
    if (bus.iIfWe) begin
      ifBase = bus.iMcuWriteData[NUM_IRQ-1:0] | bus.iIrq;
    end
  end

  // IME after EI/DI/RETI; DI has the last word
  always_comb begin
    imeBase = ime;
    if (bus.iDi) begin
      imeBase = 1'b0;
    end else if (bus.iReti || eiFire) begin
      imeBase = 1'b1;
    end
  end

  // Registers and arbitration FSM
  always_ff @(posedge iClock) begin
    if (iReset) begin
      ifReg    <= '0;
      ieReg    <= '0;
      ime      <= 1'b0;
      state    <= ST_IDLE;
      winLatch <= '0;
      irqReq   <= 1'b0;
    end else begin
      ifReg <= ifBase;
      ime   <= imeBase;
      if (bus.iIeWe) begin
        ieReg <= bus.iMcuWriteData;
      end

      case (state)
        ST_IDLE: begin
          if (ime && found) begin
            state           <= ST_REQ;
            winLatch.idx    <= winIdx;
            winLatch.vector <= irqVector(VECTOR_BASE, winIdx);
            irqReq          <= 1'b1;
          end
        end

        ST_REQ: begin
          // Withdraw as soon as this cycle's writes/DI kill the request
          if (!imeBase || !ifBase[winLatch.idx]) begin
            state  <= ST_IDLE;
            irqReq <= 1'b0;
          end else if (bus.iIrqAck) begin
            state                <= ST_DISPATCH;
            irqReq               <= 1'b0;
            ime                  <= 1'b0;
            ifReg[winLatch.idx]  <= bus.iIrq[winLatch.idx];
          end
        end

        ST_DISPATCH: begin
          state <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          irqReq <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oIf        = {3'b111, ifReg};
  assign bus.oIe        = ieReg;
  assign bus.oIrqReq    = irqReq;
  assign bus.oIrqVector = winLatch.vector;
  assign bus.oWake      = |pending;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interrupt_ctrl
// Per-cycle stimulus/expectation table for interrupt_ctrl plus a short
// EI-timing sequence that depends on INTCTRL_EI_DELAY_EN. Expectations are
// queued when a row is driven and compared after the following clock edge.
// -----------------------------------------------------------------------------
module tb_interrupt_ctrl;

  logic iClock = 1'b0;
  logic iReset;

  interrupt_ctrl_if bus ();

  interrupt_ctrl #(.VECTOR_BASE(8'h40)) dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic       rst;
    logic [4:0] irq;
    logic [1:0] wr;     // {ieWe, ifWe}
    logic [7:0] data;
    logic [3:0] cpu;    // {ei, di, reti, eof}
    logic       ack;
    logic [7:0] expIf;
    logic [7:0] expIe;
    logic       expReq;
    logic       chkVec;
    logic [7:0] expVec;
    logic       expWake;
  } row_t;

  typedef struct {
    int         tag;
    logic [7:0] ifv;
    logic [7:0] iev;
    logic       req;
    logic       chkVec;
    logic [7:0] vec;
    logic       wake;
  } exp_t;

  localparam logic [1:0] WIF  = 2'b01;
  localparam logic [1:0] WIE  = 2'b10;
  localparam logic [3:0] EI   = 4'b1000;
  localparam logic [3:0] DI   = 4'b0100;
  localparam logic [3:0] RETI = 4'b0010;
  localparam logic [3:0] EOF  = 4'b0001;

  row_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic row_t mk(input logic rst, input logic [4:0] irq,
                              input logic [1:0] wr, input logic [7:0] data,
                              input logic [3:0] cpu, input logic ack,
                              input logic [7:0] eIf, input logic [7:0] eIe,
                              input logic eReq, input logic cVec,
                              input logic [7:0] eVec, input logic eWake);
    row_t r;
    r.rst = rst; r.irq = irq; r.wr = wr; r.data = data; r.cpu = cpu; r.ack = ack;
    r.expIf = eIf; r.expIe = eIe; r.expReq = eReq; r.chkVec = cVec;
    r.expVec = eVec; r.expWake = eWake;
    return r;
  endfunction

  task automatic chk(input string name, input int tag,
                     input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %02h expected %02h", name, tag, got, exp);
    end
  endtask

  task automatic checkOut();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk("oIf", e.tag, bus.oIf, e.ifv);
      chk("oIe", e.tag, bus.oIe, e.iev);
      chk("oIrqReq", e.tag, 8'(bus.oIrqReq), 8'(e.req));
      chk("oWake", e.tag, 8'(bus.oWake), 8'(e.wake));
      if (e.chkVec) chk("oIrqVector", e.tag, bus.oIrqVector, e.vec);
    end
  endtask

  task automatic applyRow(input row_t r, input int tag);
    exp_t e;
    iReset            = r.rst;
    bus.iIrq          = r.irq;
    bus.iIfWe         = r.wr[0];
    bus.iIeWe         = r.wr[1];
    bus.iMcuWriteData = r.data;
    bus.iEi           = r.cpu[3];
    bus.iDi           = r.cpu[2];
    bus.iReti         = r.cpu[1];
    bus.iEof          = r.cpu[0];
    bus.iIrqAck       = r.ack;
    e = '{tag: tag, ifv: r.expIf, iev: r.expIe, req: r.expReq,
          chkVec: r.chkVec, vec: r.expVec, wake: r.expWake};
    sb.push_back(e);
    @(posedge iClock);
    #1;
    checkOut();
  endtask

  initial begin
    iReset = 1'b1;
    bus.iIrq = '0; bus.iEof = 0; bus.iEi = 0; bus.iDi = 0; bus.iReti = 0;
    bus.iIfWe = 0; bus.iIeWe = 0; bus.iMcuWriteData = '0; bus.iIrqAck = 0;

    //                rst irq      wr   data   cpu  ack  IF     IE     req cv vec    wake
    // Reset, then IE=0x04, EI, EOF, timer pulse
    tbl.push_back(mk(1, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE0, 8'h00, 0, 1, 8'h00, 0)); // 0
    tbl.push_back(mk(0, 5'h00, WIE,  8'h04, 4'h0, 0, 8'hE0, 8'h04, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, EI,   0, 8'hE0, 8'h04, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, EOF,  0, 8'hE0, 8'h04, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h04, 2'b0, 8'h00, 4'h0, 0, 8'hE4, 8'h04, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE4, 8'h04, 1, 1, 8'h50, 1)); // 5
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE4, 8'h04, 1, 1, 8'h50, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 1, 8'hE0, 8'h04, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE0, 8'h04, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h04, 2'b0, 8'h00, 4'h0, 0, 8'hE4, 8'h04, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE4, 8'h04, 0, 0, 8'h00, 1)); // 10
    // Three simultaneous sources, served in priority order across RETI
    tbl.push_back(mk(0, 5'h00, WIE,  8'h1F, 4'h0, 0, 8'hE4, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, WIF,  8'h00, 4'h0, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, RETI, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h16, 2'b0, 8'h00, 4'h0, 0, 8'hF6, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hF6, 8'h1F, 1, 1, 8'h48, 1)); // 15
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 1, 8'hF4, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hF4, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, RETI, 0, 8'hF4, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hF4, 8'h1F, 1, 1, 8'h50, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 1, 8'hF0, 8'h1F, 0, 0, 8'h00, 1)); // 20
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, RETI, 0, 8'hF0, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hF0, 8'h1F, 1, 1, 8'h60, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 1, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    // Request withdrawn by an IF write of 0; IME untouched
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, RETI, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0)); // 25
    tbl.push_back(mk(0, 5'h01, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 1, 1, 8'h40, 1));
    tbl.push_back(mk(0, 5'h00, WIF,  8'h00, 4'h0, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h01, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1)); // 30
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 1, 1, 8'h40, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 1, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    // IF write races a request; writes of 1 set bits
    tbl.push_back(mk(0, 5'h01, WIF,  8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, WIF,  8'h1E, 4'h0, 0, 8'hFE, 8'h1F, 0, 0, 8'h00, 1)); // 35
    tbl.push_back(mk(0, 5'h00, WIF,  8'h00, 4'h0, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    // Wake without IME, then reset in the middle of a request
    tbl.push_back(mk(0, 5'h00, WIE,  8'h01, 4'h0, 0, 8'hE0, 8'h01, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h01, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h01, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h01, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, RETI, 0, 8'hE1, 8'h01, 0, 0, 8'h00, 1)); // 40
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h01, 1, 1, 8'h40, 1));
    tbl.push_back(mk(1, 5'h1F, 2'b0, 8'h00, 4'h0, 0, 8'hE0, 8'h00, 0, 1, 8'h00, 0));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE0, 8'h00, 0, 1, 8'h00, 0));
    // Latched vector holds when a higher-priority source arrives in REQ
    tbl.push_back(mk(0, 5'h00, WIE,  8'h1F, 4'h0, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, RETI, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0)); // 45
    tbl.push_back(mk(0, 5'h10, 2'b0, 8'h00, 4'h0, 0, 8'hF0, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hF0, 8'h1F, 1, 1, 8'h60, 1));
    tbl.push_back(mk(0, 5'h01, 2'b0, 8'h00, 4'h0, 0, 8'hF1, 8'h1F, 1, 1, 8'h60, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hF1, 8'h1F, 1, 1, 8'h60, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 1, 8'hE1, 8'h1F, 0, 0, 8'h00, 1)); // 50
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    // Same-bit request during ack keeps the bit
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, RETI, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 1, 1, 8'h40, 1));
    tbl.push_back(mk(0, 5'h01, 2'b0, 8'h00, 4'h0, 1, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1)); // 55
    // DI withdraws a request; EI+DI leaves IME clear
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, RETI, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 1, 1, 8'h40, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, DI,   0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, EI|DI,0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1)); // 60
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, EOF,  0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1));

    @(posedge iClock);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      applyRow(tbl[i], i);
    end

    // EI timing from IDLE with IF=0xE1, IE=0x1F, IME=0
`ifdef INTCTRL_EI_DELAY_EN
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, EI,   0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1), 100);
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1), 101);
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1), 102);
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, EOF,  0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1), 103);
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 1, 1, 8'h40, 1), 104);
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 1, 8'hE0, 8'h1F, 0, 0, 8'h00, 0), 105);
`else
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, EI,   0, 8'hE1, 8'h1F, 0, 0, 8'h00, 1), 100);
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE1, 8'h1F, 1, 1, 8'h40, 1), 101);
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 1, 8'hE0, 8'h1F, 0, 0, 8'h00, 0), 102);
`endif
    applyRow(mk(0, 5'h00, 2'b0, 8'h00, 4'h0, 0, 8'hE0, 8'h1F, 0, 0, 8'h00, 0), 110);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
